ps2_rx_ctrl: RTL and testbench
==============================

Name: ps2_rx_ctrl

Overview:
Receive-side sequencer for the PS2 keyboard port behind the wishbone PS2 slave. It synchronises and de-glitches ps2_clk/ps2_dat, steps an 11-bit frame state machine, checks parity/framing/timeout, and buffers good scan codes in a small show-ahead FIFO. The wishbone slave wrapper reads the FIFO and forwards interrupt/intererr to the CPU.

Parameters:
FILTER_LEN, 8, consecutive stable clk cycles required before filtered ps2_clk changes (>=2)
TIMEOUT_CYC, 100000, clk cycles without a filtered falling edge that aborts a frame in progress (2 ms at 50 MHz)
FIFO_DEPTH, 4, scan-code buffer entries (power of 2, >=2)
CNT_W, 3, width of fifo_cnt (log2(FIFO_DEPTH)+1)

Ports:
clk  in  1  system clock, must exceed ps2_clk by >=50x
rst  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS2 clock line (asynchronous)
ps2_dat  in  1  raw PS2 data line (asynchronous)
rd_en  in  1  pop head entry; ignored when fifo empty
rd_data  out  8  head entry (show-ahead), valid while fifo_cnt != 0
fifo_cnt  out  CNT_W  entries held, 0..FIFO_DEPTH
busy  out  1  1 while frame state != IDLE
interrupt  out  1  level, 1 while fifo_cnt != 0
intererr  out  1  one-cycle pulse per detected error
err_code  out  2  cause of last error: 0 parity, 1 framing, 2 timeout, 3 overflow; held until next error

Behaviour:
- Reset (rst=0, async): state IDLE, fifo empty, fifo_cnt 0, rd_data 0, busy 0, interrupt 0, intererr 0, err_code 0, filtered clk 1, sync FFs 1, timeout counter 0.
- Input path: both lines through 2-FF synchronisers. Filtered clk takes synced value only after it differs from current filtered value for FILTER_LEN consecutive cycles; shorter pulses have no effect. Falling edge = filtered 1->0; bit sampled from synced ps2_dat in that same cycle.
- Frame FSM (advances only on falling edge, except timeout):
  IDLE: bit 0 -> DATA, bit cnt 0, parity acc 0. Bit 1 -> intererr, err_code 1, stay IDLE.
  DATA: shift in LSB first, xor into acc; after 8th bit -> PARITY.
  PARITY: store bit -> STOP.
  STOP: always -> IDLE. Stop bit 0 -> framing error (code 1). Else data^parity not odd -> parity error (code 0). Else push byte.
- Error priority at STOP: framing > parity > overflow. Only one intererr per frame.
- Timeout: counter clears on every falling edge and in IDLE; counts in DATA/PARITY/STOP; reaching TIMEOUT_CYC -> IDLE, intererr, err_code 2, byte discarded.
- Push: the cycle after STOP edge. Fifo full and no simultaneous pop -> byte dropped, intererr, err_code 3. Full with rd_en same cycle -> pop then push, fifo_cnt stays FIFO_DEPTH, no error.
- Pop: rd_en with fifo_cnt!=0 advances head next cycle; rd_en when empty is ignored, no error. Push+pop when not empty/full -> fifo_cnt unchanged.
- fifo_cnt, rd_data, interrupt registered, updated same edge as push/pop; interrupt == (fifo_cnt!=0) always.
- Pointers wrap modulo FIFO_DEPTH; fifo_cnt never exceeds FIFO_DEPTH or underflows.
- Latency: byte visible on rd_data exactly 2 clk after the clk cycle in which the stop-bit falling edge is detected (edge detect, then push).
- Reset mid-frame: partial frame discarded, no intererr; next complete frame after release received normally.

Test Plan:
1. FILTER_LEN 4, TIMEOUT_CYC 2000, ps2 period 200 clk: send 0x1C, parity 0, stop 1 -> rd_data 0x1C, fifo_cnt 1, interrupt 1, no intererr; rd_en one cycle -> fifo_cnt 0, interrupt 0.
2. Send 0x1C with parity 1 -> one intererr pulse, err_code 0, fifo_cnt 0; then 0xF0 with stop 0 -> intererr, err_code 1, fifo_cnt 0.
3. Send 0x01..0x05 with no reads -> fifo_cnt 4 after 4th, 5th gives intererr, err_code 3; four pops return 0x01,0x02,0x03,0x04.
4. Start + 4 data bits then lines idle high 2000 clk -> intererr, err_code 2, busy 0; then 0x5A received correctly.
5. 3-cycle low glitch on ps2_clk in IDLE -> busy stays 0, no intererr; assert rst for 1 cycle after 6th data bit -> all outputs at reset values, next frame 0x29 received clean.
6. Fifo full, hold rd_en in the push cycle of a 5th byte 0x33 -> no intererr, fifo_cnt 4, later pops return 0x02,0x03,0x04,0x33.

Source files
------------

// File: rtl/ps2_rx_ctrl_if.sv
// Read-side bundle between the PS2 receive controller and the wishbone wrapper.
// The wrapper is the master (it pops); the receive controller is the slave.
interface ps2_rx_ctrl_if #(
   parameter int CNT_W = 3
);
   logic             rd_en;
   logic [7:0]       rd_data;
   logic [CNT_W-1:0] fifo_cnt;
   logic             busy;
   logic             interrupt;
   logic             intererr;
   logic [1:0]       err_code;

   modport master (output rd_en, input rd_data, fifo_cnt, busy, interrupt, intererr, err_code);
   modport slave  (input rd_en, output rd_data, fifo_cnt, busy, interrupt, intererr, err_code);
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS2 receive sequencer: synchronise and filter the PS2 lines, decode 11-bit frames,
// and queue good scan codes in a show-ahead FIFO.
module ps2_rx_ctrl #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         ps2_clk_i,
   input  logic         ps2_dat_i,
   ps2_rx_ctrl_if.slave bus
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

   state_e           state_q, state_d;
   logic [1:0]       clkSync_q, datSync_q;
   logic             filtClk_q, filtClk_d;
   logic [FW-1:0]    filtCnt_q, filtCnt_d;
   logic             fallEdge, bitIn;
   logic [2:0]       bitCnt_q, bitCnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             parAcc_q, parAcc_d;
   logic             parBit_q, parBit_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             pushReq_q, pushReq_d;
   logic             frameErr;
   logic [1:0]       frameErrCode;

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wrPtr_q, rdPtr_q, headNext;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       rdData_q, rdData_d;
   logic             interrupt_q;
   logic             intererr_q, intererr_d;
   logic [1:0]       errCode_q, errCode_d;
   logic             doPop, doPush, overflow;

   // The filtered clock only follows the synchronised line after FILTER_LEN
   // consecutive disagreeing cycles; a falling edge is the cycle it flips to 0.
   always_comb begin
      filtClk_d = filtClk_q;
      filtCnt_d = '0;
      if (clkSync_q[1] != filtClk_q) begin
         if (filtCnt_q == FW'(FILTER_LEN - 1)) filtClk_d = clkSync_q[1];
         else filtCnt_d = filtCnt_q + FW'(1);
      end
      fallEdge = filtClk_q & ~filtClk_d;
      bitIn    = datSync_q[1];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clkSync_q <= 2'b11;
         datSync_q <= 2'b11;
         filtClk_q <= 1'b1;
         filtCnt_q <= '0;
      end else begin
         clkSync_q <= {clkSync_q[0], ps2_clk_i};
         datSync_q <= {datSync_q[0], ps2_dat_i};
         filtClk_q <= filtClk_d;
         filtCnt_q <= filtCnt_d;
      end
   end

   // Frame decoder; a falling edge in the same cycle as the timeout limit wins,
   // because every edge restarts the inactivity count.
   always_comb begin
      state_d      = state_q;
      bitCnt_d     = bitCnt_q;
      shift_d      = shift_q;
      parAcc_d     = parAcc_q;
      parBit_d     = parBit_q;
      timer_d      = '0;
      pushReq_d    = 1'b0;
      frameErr     = 1'b0;
      frameErrCode = 2'd0;
      if (state_q != IDLE && !fallEdge) begin
         if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d      = IDLE;
            frameErr     = 1'b1;
            frameErrCode = 2'd2;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
      if (fallEdge) begin
         case (state_q)
            IDLE: begin
               if (bitIn) begin
                  frameErr     = 1'b1;
                  frameErrCode = 2'd1;
               end else begin
                  state_d  = DATA;
                  bitCnt_d = 3'd0;
                  parAcc_d = 1'b0;
               end
            end
            DATA: begin
               shift_d  = {bitIn, shift_q[7:1]};
               parAcc_d = parAcc_q ^ bitIn;
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parBit_d = bitIn;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!bitIn) begin
                  frameErr     = 1'b1;
                  frameErrCode = 2'd1;
               end else if (!(parAcc_q ^ parBit_q)) begin
                  frameErr     = 1'b1;
                  frameErrCode = 2'd0;
               end else begin
                  pushReq_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         parAcc_q  <= 1'b0;
         parBit_q  <= 1'b0;
         timer_q   <= '0;
         pushReq_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         parAcc_q  <= parAcc_d;
         parBit_q  <= parBit_d;
         timer_q   <= timer_d;
         pushReq_q <= pushReq_d;
      end
   end

   // The byte still sits in shift_q during the push cycle, since no new data bit
   // can arrive within one cycle of the stop edge. A full FIFO accepts the push
   // only when a pop frees the head in the same cycle.
   always_comb begin
      doPop    = bus.rd_en && (cnt_q != '0);
      overflow = pushReq_q && (cnt_q == CNT_W'(FIFO_DEPTH)) && !doPop;
      doPush   = pushReq_q && !overflow;
      cnt_d    = cnt_q;
      if (doPush && !doPop) cnt_d = cnt_q + CNT_W'(1);
      else if (doPop && !doPush) cnt_d = cnt_q - CNT_W'(1);
      headNext = doPop ? rdPtr_q + PW'(1) : rdPtr_q;
      rdData_d = rdData_q;
      if ((cnt_q - CNT_W'(doPop)) != '0) rdData_d = mem_q[headNext];
      else if (doPush) rdData_d = shift_q;
      intererr_d = frameErr | overflow;
      errCode_d  = errCode_q;
      if (frameErr) errCode_d = frameErrCode;
      else if (overflow) errCode_d = 2'd3;
   end

   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q] <= shift_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         cnt_q       <= '0;
         rdData_q    <= '0;
         interrupt_q <= 1'b0;
         intererr_q  <= 1'b0;
         errCode_q   <= 2'd0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
         if (doPop) rdPtr_q <= rdPtr_q + PW'(1);
         cnt_q       <= cnt_d;
         rdData_q    <= rdData_d;
         interrupt_q <= (cnt_d != '0);
         intererr_q  <= intererr_d;
         errCode_q   <= errCode_d;
      end
   end

   assign bus.rd_data   = rdData_q;
   assign bus.fifo_cnt  = cnt_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.interrupt = interrupt_q;
   assign bus.intererr  = intererr_q;
   assign bus.err_code  = errCode_q;
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: directed frame scenarios plus random frames, checked
// against a queue model of the scan-code buffer and the frame error rules.
`timescale 1ns/1ps
module tb_ps2_rx_ctrl;
   localparam int FILTER_LEN  = 4;
   localparam int TIMEOUT_CYC = 2000;
   localparam int FIFO_DEPTH  = 4;
   localparam int CNT_W       = 3;
   localparam int HALF_BIT    = 100;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic ps2Clk = 1'b1;
   logic ps2Dat = 1'b1;
   int   totalChecks = 0;
   int   badChecks   = 0;
   int   errSeen     = 0;
   logic [7:0] modelQ[$];

   ps2_rx_ctrl_if #(.CNT_W(CNT_W)) bus ();

   ps2_rx_ctrl #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .ps2_clk_i(ps2Clk),
      .ps2_dat_i(ps2Dat),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.intererr) errSeen++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // kind 0 = good frame, 1 = wrong parity, 2 = stop bit low
   function automatic logic [10:0] mkFrame(input logic [7:0] d, input int kind);
      logic par;
      logic stop;
      par  = (kind == 1) ? ^d : ~(^d);
      stop = (kind == 2) ? 1'b0 : 1'b1;
      return {stop, par, d, 1'b0};
   endfunction

   task automatic applyStimulus(input logic [10:0] frame, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk); #1;
         ps2Dat = frame[i];
         ps2Clk = 1'b1;
         repeat (HALF_BIT) @(posedge clk);
         #1 ps2Clk = 1'b0;
         repeat (HALF_BIT) @(posedge clk);
      end
   endtask

   task automatic idleLines(input int n);
      @(posedge clk); #1;
      ps2Clk = 1'b1;
      ps2Dat = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_cnt"}, bus.fifo_cnt, modelQ.size());
      checkOutput({tag, "_irq"}, bus.interrupt, modelQ.size() != 0);
      if (modelQ.size() != 0) checkOutput({tag, "_head"}, bus.rd_data, modelQ[0]);
   endtask

   task automatic expectFrame(input string tag, input logic [7:0] d, input int kind, input int errBefore);
      int expErr;
      logic [1:0] expCode;
      expErr  = 0;
      expCode = 2'd0;
      if (kind == 2) begin expErr = 1; expCode = 2'd1; end
      else if (kind == 1) begin expErr = 1; expCode = 2'd0; end
      else if (modelQ.size() >= FIFO_DEPTH) begin expErr = 1; expCode = 2'd3; end
      else modelQ.push_back(d);
      checkOutput({tag, "_errs"}, errSeen - errBefore, expErr);
      if (expErr != 0) checkOutput({tag, "_code"}, bus.err_code, expCode);
      checkState(tag);
   endtask

   task automatic sendFrame(input string tag, input logic [7:0] d, input int kind);
      int e0;
      e0 = errSeen;
      applyStimulus(mkFrame(d, kind), 11);
      idleLines(40);
      expectFrame(tag, d, kind, e0);
   endtask

   // Drives the stop bit by hand so the cycle of its falling edge is known.
   task automatic driveStopManual(input logic stopBit);
      @(posedge clk); #1;
      ps2Dat = stopBit;
      ps2Clk = 1'b1;
      repeat (HALF_BIT) @(posedge clk);
      #1 ps2Clk = 1'b0;
   endtask

   task automatic popOne(input string tag);
      if (modelQ.size() != 0) checkOutput({tag, "_pop"}, bus.rd_data, modelQ[0]);
      bus.rd_en = 1'b1;
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      if (modelQ.size() != 0) void'(modelQ.pop_front());
   endtask

   initial begin
      int e0;
      int lat;
      int k;
      bus.rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cnt", bus.fifo_cnt, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_irq", bus.interrupt, 0);
      checkOutput("rst_data", bus.rd_data, 0);
      checkOutput("rst_code", bus.err_code, 0);
      rst_n = 1'b1;
      idleLines(20);

      // 2 sync stages plus FILTER_LEN filter cycles, then push, then visible
      e0 = errSeen;
      applyStimulus(mkFrame(8'h1C, 0), 10);
      driveStopManual(1'b1);
      lat = 0;
      while (bus.fifo_cnt == 0 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("t1_latency", lat, 2 + FILTER_LEN + 1);
      idleLines(40);
      expectFrame("t1", 8'h1C, 0, e0);
      popOne("t1");
      checkState("t1_after_pop");
      popOne("t1_empty");
      checkState("t1_empty");

      sendFrame("t2_par", 8'h1C, 1);
      sendFrame("t2_stop", 8'hF0, 2);
      e0 = errSeen;
      applyStimulus(11'h7FF, 1);
      idleLines(40);
      checkOutput("t2_start_errs", errSeen - e0, 1);
      checkOutput("t2_start_code", bus.err_code, 1);
      checkOutput("t2_start_busy", bus.busy, 0);

      for (int i = 1; i <= 5; i++) sendFrame("t3_fill", 8'(i), 0);
      for (int i = 0; i < 4; i++) popOne("t3");
      checkState("t3_drained");

      for (int i = 1; i <= 4; i++) sendFrame("t6_fill", 8'(i), 0);
      e0 = errSeen;
      applyStimulus(mkFrame(8'h33, 0), 10);
      driveStopManual(1'b1);
      repeat (2 + FILTER_LEN) @(posedge clk);
      #1 bus.rd_en = 1'b1;
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      void'(modelQ.pop_front());
      modelQ.push_back(8'h33);
      idleLines(40);
      checkOutput("t6_errs", errSeen - e0, 0);
      checkState("t6_full");
      for (int i = 0; i < 4; i++) popOne("t6");
      checkState("t6_drained");

      e0 = errSeen;
      applyStimulus(mkFrame(8'hA5, 0), 5);
      idleLines(1);
      checkOutput("t4_busy_mid", bus.busy, 1);
      repeat (TIMEOUT_CYC + 100) @(posedge clk);
      #1;
      checkOutput("t4_errs", errSeen - e0, 1);
      checkOutput("t4_code", bus.err_code, 2);
      checkOutput("t4_busy", bus.busy, 0);
      checkState("t4");
      sendFrame("t4_after", 8'h5A, 0);
      popOne("t4");

      e0 = errSeen;
      @(posedge clk); #1 ps2Clk = 1'b0;
      repeat (3) @(posedge clk);
      #1 ps2Clk = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t5_glitch_busy", bus.busy, 0);
      checkOutput("t5_glitch_errs", errSeen - e0, 0);
      sendFrame("t5_code_set", 8'h12, 1);
      applyStimulus(mkFrame(8'h77, 0), 7);
      checkOutput("t5_busy_pre", bus.busy, 1);
      e0 = errSeen;
      #1;
      rst_n  = 1'b0;
      ps2Clk = 1'b1;
      ps2Dat = 1'b1;
      #1;
      checkOutput("t5_rst_busy", bus.busy, 0);
      checkOutput("t5_rst_cnt", bus.fifo_cnt, 0);
      checkOutput("t5_rst_data", bus.rd_data, 0);
      checkOutput("t5_rst_irq", bus.interrupt, 0);
      checkOutput("t5_rst_err", bus.intererr, 0);
      checkOutput("t5_rst_code", bus.err_code, 0);
      modelQ.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      idleLines(50);
      checkOutput("t5_rst_errs", errSeen - e0, 0);
      sendFrame("t5_after", 8'h29, 0);
      popOne("t5");

      for (int r = 0; r < 8; r++) begin
         k = $urandom_range(0, 5);
         sendFrame("rand", 8'($urandom_range(0, 255)), (k <= 3) ? 0 : k - 3);
         if ($urandom_range(0, 2) == 0) begin
            popOne("rand");
            checkState("rand_pop");
         end
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end
endmodule
